writeback_sequencer: RTL

//  Sequences the RV32 writeback stage and owns the register-file write port.

---
 rtl/writeback_sequencer_if.sv | 35 +++
 rtl/writeback_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/writeback_sequencer_if.sv
// Writeback-stage bundle: retiring-instruction inputs, data-memory handshake
// and register-file write port shared by the sequencer and its upstream.
interface writeback_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              instr_valid;
  logic [REG_AW-1:0] rd;
  logic              reg_wr_req;
  logic              mem_to_reg;
  logic              load_byte;
  logic              read_pc_4;
  logic [DATA_W-1:0] alu_value;
  logic [DATA_W-1:0] pc_4_value;
  logic              mem_read;
  logic              mem_ready;
  logic [DATA_W-1:0] memory_value;
  logic              reg_write;
  logic [REG_AW-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              stall;
  logic              mem_error;

  modport master (
    output instr_valid, rd, reg_wr_req, mem_to_reg, load_byte, read_pc_4,
           alu_value, pc_4_value, mem_ready, memory_value,
    input  mem_read, reg_write, reg_waddr, reg_wdata, stall, mem_error
  );

  modport slave (
    input  instr_valid, rd, reg_wr_req, mem_to_reg, load_byte, read_pc_4,
           alu_value, pc_4_value, mem_ready, memory_value,
    output mem_read, reg_write, reg_waddr, reg_wdata, stall, mem_error
  );
endinterface

// File: rtl/writeback_sequencer.sv
// RV32 writeback sequencer: picks pc+4 / ALU / memory result, runs the load
// handshake with timeout, and drives the register-file write port.
module writeback_sequencer #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 rst,
  writeback_sequencer_if.slave bus
);
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [REG_AW-1:0] rd_q;
  logic              wr_req_q;
  logic              byte_q;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] fmt_data;
  logic              is_load;

  assign bus.stall = (state == MEM_WAIT);
  assign is_load   = bus.mem_to_reg && !bus.read_pc_4;

  always_comb begin
    sel_data = bus.alu_value;
    if (bus.read_pc_4) sel_data = bus.pc_4_value;
  end

  always_comb begin
    fmt_data = bus.memory_value;
    if (byte_q) fmt_data = {{(DATA_W-8){1'b0}}, bus.memory_value[7:0]};
  end

  // Write port only updates on an actual write so waddr/wdata hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      rd_q          <= '0;
      wr_req_q      <= 1'b0;
      byte_q        <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.reg_waddr <= '0;
      bus.reg_wdata <= '0;
      bus.mem_error <= 1'b0;
    end else begin
      bus.reg_write <= 1'b0;
      bus.mem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            if (is_load) begin
              rd_q         <= bus.rd;
              wr_req_q     <= bus.reg_wr_req;
              byte_q       <= bus.load_byte;
              bus.mem_read <= 1'b1;
              count        <= '0;
              state        <= MEM_WAIT;
            end else if (bus.reg_wr_req && bus.rd != '0) begin
              bus.reg_write <= 1'b1;
              bus.reg_waddr <= bus.rd;
              bus.reg_wdata <= sel_data;
            end
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            bus.mem_read <= 1'b0;
            state        <= IDLE;
            if (wr_req_q && rd_q != '0) begin
              bus.reg_write <= 1'b1;
              bus.reg_waddr <= rd_q;
              bus.reg_wdata <= fmt_data;
            end
          end else if (count == CNT_W'(MEM_TIMEOUT - 1)) begin
            bus.mem_read  <= 1'b0;
            bus.mem_error <= 1'b1;
            state         <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
